bus_initiator: RTL and testbench
================================

// Module: bus_initiator
// PURPOSE
//   Host-side initiator for the addressed peripheral bus (buffered UART endpoints etc.).
//   Accepts read/write requests on a valid/ready port, queues them, and drives
//   bus_address / bus_read_enable / bus_write_enable / bus_wdata one transaction at a time.
//   Returns one response per request (read data or write acknowledge). Sits between CPU/test logic and peripherals.
// PARAMETERS
//   WIDTH          8   data word width (matches peripheral word width)
//   ADDRESS_WIDTH  4   bus address width
//   ACCESS_CYCLES  1   cycles enables are held per access; legal range >= 1
//   QUEUE_DEPTH    4   request queue entries; power of two, >= 2
// PORTS
//   clock             in   1              single clock, all logic on posedge
//   reset             in   1              asynchronous, active-high reset
//   req_valid         in   1              request offered
//   req_ready         out  1              queue not full; transfer when req_valid & req_ready
//   req_write         in   1              1 = write, 0 = read
//   req_address       in   ADDRESS_WIDTH  target address
//   req_wdata         in   WIDTH          write data (ignored for reads)
//   resp_valid        out  1              response available, held until resp_ready
//   resp_ready        in   1              consumer accepts response
//   resp_write        out  1              echoes req_write of completed transaction
//   resp_data         out  WIDTH          read data; 0 for writes
//   bus_address       out  ADDRESS_WIDTH  active address
//   bus_read_enable   out  1              read strobe
//   bus_write_enable  out  1              write strobe
//   bus_wdata         out  WIDTH          write data
//   bus_rdata         in   WIDTH          peripheral read data, valid the cycle after last enable cycle
//   busy              out  1              FSM not IDLE or queue non-empty
// BEHAVIOUR
//   Reset (async, immediate): all outputs 0 except req_ready=1; queue emptied; in-flight transaction dropped, no response.
//   Queue: push on req_valid & req_ready; push while full impossible (req_ready=0). Pop only in IDLE.
//     Simultaneous push+pop legal, count unchanged. Pointers wrap modulo QUEUE_DEPTH.
//   FSM states IDLE, DRIVE, CAPTURE, RESP:
//     IDLE:    enables 0, bus_address 0, bus_wdata 0. If queue non-empty: pop into hold reg, counter=0 -> DRIVE.
//     DRIVE:   drive hold address; bus_write_enable=write / bus_read_enable=~write; bus_wdata=hold data on writes,
//              0 on reads. Counter++; at counter==ACCESS_CYCLES-1 -> CAPTURE (read) or RESP (write, resp_data=0).
//     CAPTURE: enables 0, address held; register bus_rdata into resp_data -> RESP.
//     RESP:    resp_valid=1, resp_write/resp_data stable; on resp_ready -> IDLE.
//   Exactly one outstanding transaction; never both enables high; enables always low >= 1 cycle between accesses.
//   Latency (ACCESS_CYCLES=A, empty queue, resp_ready=1): request accepted cycle 0; enables high cycles 2..A+1;
//     write resp_valid cycle A+2; read resp_valid cycle A+3. Response order = request order.
//   Response backpressure: RESP held indefinitely; queue keeps accepting until full.
//   Counter width $clog2(ACCESS_CYCLES+1); no arithmetic on data.
// STRUCTURE
//   bus_initiator_pkg: state_e {IDLE, DRIVE, CAPTURE, RESP}; bus_req_t struct {write, address, wdata}
//     parameterised by widths via package localparams overridden per instance where needed.
//   One sub-module: bus_req_queue (synchronous FIFO of bus_req_t, full/empty, async active-high reset).
//   FSM, counter, hold register and response register live in bus_initiator.
// TESTING
//   1. Write 0xA5 to addr 3, A=1 -> bus_write_enable=1, bus_address=3, bus_wdata=0xA5 for 1 cycle (cycle 2);
//      resp_valid cycle 3, resp_write=1, resp_data=0.
//   2. Read addr 5, model returns 0x3C -> bus_read_enable 1 cycle, resp_valid cycle 4, resp_data=0x3C.
//   3. Push 5 requests back-to-back, resp_ready=0 -> req_ready drops after queue fills (4 queued, 1 held);
//      release resp_ready -> 5 responses in order, enables never overlap.
//   4. ACCESS_CYCLES=3, read addr 2 -> bus_read_enable high exactly 3 cycles, resp_valid 6 cycles after acceptance.
//   5. Assert reset while in DRIVE with 2 queued -> outputs 0 same cycle, req_ready=1, busy=0, no resp_valid afterwards.
//   6. Random valid/ready on both sides, 1000 transactions vs reference model -> data, order and one-hot enables match.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared types for the peripheral bus initiator: FSM states and the queued request record.
package bus_initiator_pkg;

  localparam int unsigned BUS_WIDTH         = 8;
  localparam int unsigned BUS_ADDRESS_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    RESP
  } state_e;

  // Default request layout; instances with other widths pass their own struct to the queue.
  typedef struct packed {
    logic                         write;
    logic [BUS_ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]         wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_req_queue.sv
// Synchronous FIFO of bus requests with full/empty flags and a first-word-fall-through head.
module bus_req_queue
  import bus_initiator_pkg::*;
#(
  parameter type         T     = bus_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bus_initiator.sv
// Host-side initiator: queues read/write requests and runs them one at a time on the peripheral bus.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned QUEUE_DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_write,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic                     bus_read_enable,
  output logic                     bus_write_enable,
  output logic [WIDTH-1:0]         bus_wdata,
  input  logic [WIDTH-1:0]         bus_rdata,
  output logic                     busy
);

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [WIDTH-1:0]         wdata;
  } req_t;

  localparam int unsigned      CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACCESS_CYCLES - 1);

  state_e             state_q, state_d;
  req_t               hold_q, hold_d;
  req_t               req_in, head;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_write_q, resp_write_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic               pop, full, empty;

  assign req_in = '{write: req_write, address: req_address, wdata: req_wdata};

  bus_req_queue #(
    .T     (req_t),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (req_valid),
    .push_data_i (req_in),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign req_ready  = ~full;
  assign busy       = (state_q != IDLE) | ~empty;
  assign resp_write = resp_write_q;
  assign resp_data  = resp_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      resp_write_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      resp_write_q <= resp_write_d;
      resp_data_q  <= resp_data_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    cnt_d            = cnt_q;
    resp_write_d     = resp_write_q;
    resp_data_d      = resp_data_q;
    pop              = 1'b0;
    bus_address      = '0;
    bus_wdata        = '0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    resp_valid       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = head;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        bus_address      = hold_q.address;
        bus_write_enable = hold_q.write;
        bus_read_enable  = ~hold_q.write;
        if (hold_q.write) bus_wdata = hold_q.wdata;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (hold_q.write) begin
            resp_write_d = 1'b1;
            resp_data_d  = '0;
            state_d      = RESP;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      // Peripheral data is valid only in the cycle after the last strobe.
      CAPTURE: begin
        bus_address  = hold_q.address;
        resp_write_d = 1'b0;
        resp_data_d  = bus_rdata;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Randomised and directed checks of bus_initiator (ACCESS_CYCLES 1 and 3) against a transaction-level model.
module tb_bus_initiator;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2], req_valid [2], req_ready [2], req_write [2];
  logic          resp_valid [2], resp_ready [2], resp_write [2];
  logic          bus_re [2], bus_we [2], busy [2];
  logic [AW-1:0] req_address [2], bus_address [2];
  logic [W-1:0]  req_wdata [2], resp_data [2], bus_wdata [2], bus_rdata [2];

  bus_initiator #(.WIDTH(W), .ADDRESS_WIDTH(AW), .ACCESS_CYCLES(1), .QUEUE_DEPTH(DEPTH)) u_dut_a1 (
    .clock(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_address(req_address[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_write(resp_write[0]),
    .resp_data(resp_data[0]), .bus_address(bus_address[0]), .bus_read_enable(bus_re[0]),
    .bus_write_enable(bus_we[0]), .bus_wdata(bus_wdata[0]), .bus_rdata(bus_rdata[0]), .busy(busy[0]));

  bus_initiator #(.WIDTH(W), .ADDRESS_WIDTH(AW), .ACCESS_CYCLES(3), .QUEUE_DEPTH(DEPTH)) u_dut_a3 (
    .clock(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_address(req_address[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_write(resp_write[1]),
    .resp_data(resp_data[1]), .bus_address(bus_address[1]), .bus_read_enable(bus_re[1]),
    .bus_write_enable(bus_we[1]), .bus_wdata(bus_wdata[1]), .bus_rdata(bus_rdata[1]), .busy(busy[1]));

  // Model state: log of accepted requests, consumed in order by the bus and response checkers.
  txn_t         log_q [2][64];
  int unsigned  wr_n [2], bus_n [2], rsp_n [2], done_n [2];
  logic [W-1:0] pmem [2][16], ref_mem [2][16];
  logic         re_prev [2];
  logic [AW-1:0] addr_prev [2];
  int unsigned  run [2];
  txn_t         cur_acc [2];
  logic         accepted [2], samp_en [2], samp_rv [2], samp_wr [2];
  logic [W-1:0] samp_rd [2];
  int           tests = 0, fails = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned acc(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Peripheral: read data appears only in the cycle after the last read strobe, junk otherwise.
  task automatic periph(int d);
    bus_rdata[d] = (re_prev[d] && !bus_re[d]) ? pmem[d][addr_prev[d]] : W'($urandom);
    if (bus_we[d]) pmem[d][bus_address[d]] = bus_wdata[d];
    re_prev[d]   = bus_re[d];
    addr_prev[d] = bus_address[d];
  endtask

  task automatic monitor(int d);
    int unsigned n;
    txn_t e;
    accepted[d] = 1'b0;
    samp_en[d] = bus_re[d] | bus_we[d];
    samp_rv[d] = resp_valid[d];
    samp_rd[d] = resp_data[d];
    samp_wr[d] = resp_write[d];
    if (rst[d]) begin
      wr_n[d] = 0; bus_n[d] = 0; rsp_n[d] = 0; run[d] = 0;
      for (int i = 0; i < 16; i++) ref_mem[d][i] = pmem[d][i];
      return;
    end
    n = wr_n[d] - rsp_n[d];
    check_eq($sformatf("d%0d busy", d), busy[d], n != 0);
    if (n < DEPTH) check_eq($sformatf("d%0d ready_open", d), req_ready[d], 1);
    else if (n > DEPTH) check_eq($sformatf("d%0d ready_full", d), req_ready[d], 0);
    check_eq($sformatf("d%0d en_overlap", d), bus_re[d] & bus_we[d], 0);
    if (bus_re[d] | bus_we[d]) begin
      if (run[d] == 0) cur_acc[d] = '{w: bus_we[d], addr: bus_address[d], data: bus_wdata[d]};
      else check_eq($sformatf("d%0d acc_stable", d),
                    {bus_we[d], bus_address[d], bus_wdata[d]}, cur_acc[d]);
      run[d]++;
    end else if (run[d] != 0) begin
      check_eq($sformatf("d%0d acc_len", d), run[d], acc(d));
      check_eq($sformatf("d%0d acc_pending", d), bus_n[d] < wr_n[d], 1);
      if (bus_n[d] < wr_n[d]) begin
        e = log_q[d][bus_n[d] & 63];
        check_eq($sformatf("d%0d acc_fields", d), cur_acc[d],
                 {e.w, e.addr, e.w ? e.data : 8'h00});
        bus_n[d]++;
      end
      run[d] = 0;
    end
    if (resp_valid[d] && resp_ready[d]) begin
      check_eq($sformatf("d%0d rsp_pending", d), bus_n[d] > rsp_n[d], 1);
      if (bus_n[d] > rsp_n[d]) begin
        e = log_q[d][rsp_n[d] & 63];
        check_eq($sformatf("d%0d rsp_write", d), resp_write[d], e.w);
        check_eq($sformatf("d%0d rsp_data", d), resp_data[d], e.w ? 8'h00 : ref_mem[d][e.addr]);
        if (e.w) ref_mem[d][e.addr] = e.data;
        rsp_n[d]++;
        done_n[d]++;
      end
    end
    if (req_valid[d] && req_ready[d]) begin
      log_q[d][wr_n[d] & 63] = '{w: req_write[d], addr: req_address[d], data: req_wdata[d]};
      wr_n[d]++;
      accepted[d] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) periph(d);
    for (int d = 0; d < 2; d++) monitor(d);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int d, logic v, logic w, logic [AW-1:0] a, logic [W-1:0] wd);
    req_valid[d] = v; req_write[d] = w; req_address[d] = a; req_wdata[d] = wd;
  endtask

  // Single request on an idle DUT; checks cycle placement of strobes and response.
  task automatic directed(int d, logic w, logic [AW-1:0] a, logic [W-1:0] wd,
                          logic [W-1:0] exp_rd, string name);
    int first_en = -1, n_en = 0, first_rv = -1;
    logic [W-1:0] rd = '0;
    logic rw = 1'b0;
    resp_ready[d] = 1'b1;
    set_req(d, 1'b1, w, a, wd);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        check_eq({name, " accepted"}, accepted[d], 1);
        set_req(d, 1'b0, 1'b0, '0, '0);
      end
      if (samp_en[d]) begin
        n_en++;
        if (first_en < 0) first_en = k;
      end
      if (samp_rv[d] && first_rv < 0) begin
        first_rv = k; rd = samp_rd[d]; rw = samp_wr[d];
      end
    end
    check_eq({name, " first_en"}, first_en, 2);
    check_eq({name, " en_cycles"}, n_en, acc(d));
    check_eq({name, " rsp_cycle"}, first_rv, w ? acc(d) + 2 : acc(d) + 3);
    check_eq({name, " rsp_data"}, rd, exp_rd);
    check_eq({name, " rsp_write"}, rw, w);
  endtask

  initial begin
    int cnt, guard;
    int unsigned target, sent [2], goal [2], base [2];
    logic [W-1:0] v;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; resp_ready[d] = 1'b0; re_prev[d] = 1'b0; addr_prev[d] = '0;
      bus_rdata[d] = '0; done_n[d] = 0; sent[d] = 0;
      set_req(d, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 16; i++) pmem[d][i] = W'($urandom);
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d rst_ready", d), req_ready[d], 1);
      check_eq($sformatf("d%0d rst_outs", d),
               {resp_valid[d], resp_write[d], resp_data[d], bus_address[d], bus_re[d],
                bus_we[d], bus_wdata[d], busy[d]}, 0);
      rst[d] = 1'b0;
    end
    tick();

    directed(0, 1'b1, 4'd3, 8'hA5, 8'h00, "t1_write");
    pmem[0][5] = 8'h3C; ref_mem[0][5] = 8'h3C;
    directed(0, 1'b0, 4'd5, 8'h00, 8'h3C, "t2_read");
    v = W'($urandom);
    pmem[1][2] = v; ref_mem[1][2] = v;
    directed(1, 1'b0, 4'd2, 8'h00, v, "t4_read_a3");

    // Backpressure: 4 queued + 1 held, then a sixth request must stall.
    resp_ready[0] = 1'b0;
    cnt = 0; guard = 0;
    set_req(0, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
    while (cnt < 5 && guard < 30) begin
      tick(); guard++;
      if (accepted[0]) begin
        cnt++;
        set_req(0, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
      end
    end
    check_eq("t3 accepted5", cnt, 5);
    repeat (6) begin
      tick();
      if (accepted[0]) cnt++;
    end
    check_eq("t3 no_sixth", cnt, 5);
    check_eq("t3 ready_low", req_ready[0], 0);
    check_eq("t3 resp_held", resp_valid[0], 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    resp_ready[0] = 1'b1;
    target = done_n[0] + 5;
    guard = 0;
    while (done_n[0] < target && guard < 60) begin tick(); guard++; end
    check_eq("t3 drained", done_n[0], target);
    tick();

    // Reset in DRIVE with two requests still queued.
    resp_ready[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 1'b0, 4'($urandom), 8'h00);
      tick();
      if (accepted[1]) cnt++;
    end
    set_req(1, 1'b0, 1'b0, '0, '0);
    check_eq("t5 pushed3", cnt, 3);
    check_eq("t5 in_drive", bus_re[1], 1);
    #1 rst[1] = 1'b1;
    #1;
    check_eq("t5 rst_ready", req_ready[1], 1);
    check_eq("t5 rst_outs", {resp_valid[1], bus_address[1], bus_re[1], bus_we[1],
                             bus_wdata[1], busy[1]}, 0);
    tick();
    rst[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("t5 no_resp", samp_rv[1], 0);
    end

    // Random traffic on both DUTs.
    goal[0] = 1000; goal[1] = 300;
    for (int d = 0; d < 2; d++) begin base[d] = done_n[d]; sent[d] = 0; end
    guard = 0;
    while ((done_n[0] - base[0] < goal[0] || done_n[1] - base[1] < goal[1]) && guard < 40000) begin
      for (int d = 0; d < 2; d++) begin
        if (accepted[d]) sent[d]++;
        if (accepted[d] || !req_valid[d]) begin
          if (sent[d] < goal[d] && $urandom_range(0, 2) != 0)
            set_req(d, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
          else
            set_req(d, 1'b0, 1'b0, '0, '0);
        end
        resp_ready[d] = ($urandom_range(0, 9) < 6);
      end
      tick(); guard++;
    end
    check_eq("rand d0 done", done_n[0] - base[0], goal[0]);
    check_eq("rand d1 done", done_n[1] - base[1], goal[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
